bus_deserializer: RTL

BUS_DESERIALIZER -- requirements
Module: bus_deserializer

---
 rtl/bus_deserializer.sv | 61 ++++++
 1 files changed

// File: rtl/bus_deserializer.sv
// bus_deserializer: assembles LSB-first byte frames into an address/data word with framing-error tracking.
module bus_deserializer #(
  parameter int ADDRW = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [7:0]       in_data,
  input  logic             in_src,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ADDRW-1:0] out_addr,
  output logic [7:0]       out_data,
  output logic             out_src,
  output logic             err_pulse,
  output logic [7:0]       err_count
);
  localparam int NB = ADDRW / 8 + 1;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NB - 1);
  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;
  state_t          state;
  logic [IW-1:0]   idx;
  logic [8*NB-1:0] word;
  logic            acc;
  logic            err;
  assign in_ready  = state != FULL || out_ready;
  assign acc       = in_valid && in_ready;
  // SOF is only legal outside COLLECT; a non-SOF byte is only legal inside it
  assign err       = acc && (in_sof ? state == COLLECT : state != COLLECT);
  assign out_valid = state == FULL;
  assign out_addr  = word[ADDRW+7:8];
  assign out_data  = word[7:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      word      <= '0;
      out_src   <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= err;
      if (err && err_count != 8'hFF) err_count <= err_count + 1'b1;
      if (acc && in_sof) begin
        word[7:0] <= in_data;
        out_src   <= in_src;
        idx       <= NB == 1 ? '0 : IW'(1);
        state     <= NB == 1 ? FULL : COLLECT;
      end else if (acc && state == COLLECT) begin
        word[{idx, 3'b000} +: 8] <= in_data;
        idx <= idx == LAST ? '0 : idx + 1'b1;
        if (idx == LAST) state <= FULL;
      end else if (state == FULL && out_ready) begin
        state <= IDLE;
      end
    end
  end
endmodule
